// File: rtl/digital_clock_alarm.sv
// Digital clock with seconds prescaler, time-set mode, programmable alarm,
// configurable chime and 12/24 h display. Time is held as 24 h BCD bytes.
module digital_clock_alarm #(
  parameter int CLK_DIV         = 1,
  parameter int CHIME_LEN       = 5,
  parameter int CHIME_EVERY_MIN = 0,
  parameter int ALARM_SEC       = 30
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       clk_audio,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  input  logic       alarm_on,
  input  logic       alarm_ack,
  input  logic       mode_12h,
  output logic [3:0] sec_l,
  output logic [3:0] sec_h,
  output logic [3:0] min_l,
  output logic [3:0] min_h,
  output logic [3:0] hour_l,
  output logic [3:0] hour_h,
  output logic       pm,
  output logic       tick,
  output logic       alarm_active,
  output logic       beep
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    CHIME_LIM = 8'(CHIME_LEN);
  localparam logic [5:0]    ALARM_MAX = 6'(ALARM_SEC - 1);
  localparam bit            EVERY_MIN = (CHIME_EVERY_MIN != 0);

  // BCD increment of an hour byte, 23 wraps to 00
  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23) begin
      r = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      r = {h[7:4] + 4'd1, 4'd0};
    end else begin
      r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD increment of a minute/second byte, 59 wraps to 00
  function automatic logic [7:0] inc_mod60(input logic [7:0] m);
    logic [7:0] r;
    if (m == 8'h59) begin
      r = 8'h00;
    end else if (m[3:0] == 4'd9) begin
      r = {m[7:4] + 4'd1, 4'd0};
    end else begin
      r = {m[7:4], m[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [PW-1:0] presc_r;
  logic [7:0]    hour_r, min_r, sec_r;
  logic [7:0]    al_hour_r, al_min_r;
  logic          alarm_active_r;
  logic [5:0]    alarm_cnt_r;
  logic          beep_en_r;

  logic [7:0]    hour_n, min_n, sec_n, al_hour_n, al_min_n;
  logic          tick_s, match_s, active_n, chime_s, pre_ok_s, post_ok_s;
  logic [5:0]    cnt_n;
  logic [4:0]    hour_bin_s, hour12_s;
  logic [7:0]    disp_hour_s;
  logic          pm_s;

  assign tick_s = ~set_en & (presc_r == PRESC_MAX);

  // Seconds prescaler, parked at 0 while setting
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_r <= '0;
    end else if (set_en) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Next time / alarm time: field edits in set mode, otherwise carry chain on tick
  always_comb begin
    hour_n    = hour_r;
    min_n     = min_r;
    sec_n     = sec_r;
    al_hour_n = al_hour_r;
    al_min_n  = al_min_r;
    if (set_en && set_inc) begin
      case (set_sel)
        2'd0:    hour_n = inc_hour(hour_r);
        2'd1:    begin
          min_n = inc_mod60(min_r);
          sec_n = 8'h00;
        end
        2'd2:    al_hour_n = inc_hour(al_hour_r);
        2'd3:    al_min_n  = inc_mod60(al_min_r);
        default: hour_n = hour_r;
      endcase
    end else if (tick_s) begin
      sec_n = inc_mod60(sec_r);
      if (sec_r == 8'h59) begin
        min_n = inc_mod60(min_r);
        if (min_r == 8'h59) begin
          hour_n = inc_hour(hour_r);
        end else begin
          hour_n = hour_r;
        end
      end else begin
        min_n = min_r;
      end
    end else begin
      sec_n = sec_r;
    end
  end

  // Alarm start/stop; a match on this tick wins over a simultaneous ack
  always_comb begin
    match_s  = tick_s & alarm_on & (hour_n == al_hour_r) & (min_n == al_min_r)
             & (sec_n == 8'h00);
    active_n = alarm_active_r;
    cnt_n    = alarm_cnt_r;
    if (match_s) begin
      active_n = 1'b1;
      cnt_n    = 6'd0;
    end else if (alarm_active_r) begin
      if (alarm_ack || !alarm_on || set_en) begin
        active_n = 1'b0;
        cnt_n    = 6'd0;
      end else if (tick_s) begin
        if (alarm_cnt_r == ALARM_MAX) begin
          active_n = 1'b0;
          cnt_n    = 6'd0;
        end else begin
          cnt_n = alarm_cnt_r + 6'd1;
        end
      end else begin
        cnt_n = alarm_cnt_r;
      end
    end else begin
      active_n = 1'b0;
      cnt_n    = 6'd0;
    end
  end

  // Chime pattern evaluated on the time being loaded, so beep_en lines up with the display
  always_comb begin
    pre_ok_s  = EVERY_MIN || (min_n == 8'h59);
    post_ok_s = EVERY_MIN || (min_n == 8'h00);
    chime_s   = 1'b0;
    if (set_en) begin
      chime_s = 1'b0;
    end else if (pre_ok_s && (sec_n[7:4] == 4'd5)) begin
      chime_s = (sec_n[3:0] == 4'd9) | ~sec_n[0];
    end else if (post_ok_s && (sec_n < CHIME_LIM)) begin
      chime_s = 1'b1;
    end else begin
      chime_s = 1'b0;
    end
  end

  // Time, alarm and beep state registers
  always_ff @(posedge clk) begin
    if (clr) begin
      hour_r         <= 8'h00;
      min_r          <= 8'h00;
      sec_r          <= 8'h00;
      al_hour_r      <= 8'h00;
      al_min_r       <= 8'h00;
      alarm_active_r <= 1'b0;
      alarm_cnt_r    <= 6'd0;
      beep_en_r      <= 1'b0;
    end else begin
      hour_r         <= hour_n;
      min_r          <= min_n;
      sec_r          <= sec_n;
      al_hour_r      <= al_hour_n;
      al_min_r       <= al_min_n;
      alarm_active_r <= active_n;
      alarm_cnt_r    <= cnt_n;
      beep_en_r      <= chime_s | active_n;
    end
  end

  // 12/24 h display mapping of the stored hour
  always_comb begin
    hour_bin_s = ({1'b0, hour_r[7:4]} * 5'd10) + {1'b0, hour_r[3:0]};
    hour12_s   = hour_bin_s;
    if (mode_12h) begin
      pm_s = (hour_bin_s >= 5'd12);
      if (hour_bin_s == 5'd0) begin
        hour12_s = 5'd12;
      end else if (hour_bin_s > 5'd12) begin
        hour12_s = hour_bin_s - 5'd12;
      end else begin
        hour12_s = hour_bin_s;
      end
      if (hour12_s >= 5'd10) begin
        disp_hour_s = {4'd1, 4'(hour12_s - 5'd10)};
      end else begin
        disp_hour_s = {4'd0, hour12_s[3:0]};
      end
    end else begin
      pm_s        = 1'b0;
      disp_hour_s = hour_r;
    end
  end

  assign sec_l        = sec_r[3:0];
  assign sec_h        = sec_r[7:4];
  assign min_l        = min_r[3:0];
  assign min_h        = min_r[7:4];
  assign hour_l       = disp_hour_s[3:0];
  assign hour_h       = disp_hour_s[7:4];
  assign pm           = pm_s;
  assign tick         = tick_s;
  assign alarm_active = alarm_active_r;
  assign beep         = beep_en_r & clk_audio;

endmodule

// File: doc/digital_clock_alarm.md
Name: digital_clock_alarm

Overview:
Parametrised successor of the team's 24 h BCD clock/chime block. It adds an internal seconds prescaler, a time-set mode, a programmable alarm and a 12/24 h display mode. The hourly chime is configurable (top-of-hour or every-minute test mode). It sits between the board clock and the six 7-segment digit drivers and the buzzer pin.

Parameters:
CLK_DIV, 1, clk cycles per second tick (1 = clk is already 1 Hz); prescaler width is ceil(log2(CLK_DIV)), minimum 1.
CHIME_LEN, 5, seconds of continuous chime after the hour rolls over (1..9).
CHIME_EVERY_MIN, 0, 0 = chime at top of hour only; 1 = every minute (test mode).
ALARM_SEC, 30, alarm ring duration in seconds (1..59).

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset
clk_audio  in  1  audio tone clock, gated onto beep
set_en  in  1  1 = set mode: time frozen, set_inc edits the field chosen by set_sel
set_sel  in  2  0 = hour, 1 = minute, 2 = alarm hour, 3 = alarm minute
set_inc  in  1  single-cycle increment pulse
alarm_on  in  1  alarm arm enable
alarm_ack  in  1  single-cycle alarm stop pulse
mode_12h  in  1  1 = 12 h display
sec_l, sec_h, min_l, min_h, hour_l, hour_h  out  4 each  BCD display digits
pm  out  1  PM indicator (12 h mode only; 0 in 24 h mode)
tick  out  1  one-cycle pulse per second
alarm_active  out  1  alarm ringing
beep  out  1  beep_en AND clk_audio

Behaviour:
- All state updates on posedge clk. clr has priority over every other input.
- clr clears: prescaler, time to 00:00:00, alarm time to 00:00, alarm_active, beep_en.
- After clr, outputs are 00:00:00 in 24 h mode, or 12:00:00 with pm = 0 in 12 h mode. tick = 0, beep = 0.
- clr asserted mid-set or mid-alarm aborts that activity with no residual state.
- Prescaler counts 0..CLK_DIV-1. tick is asserted in the cycle where the count equals CLK_DIV-1, then the count wraps to 0.
- While set_en = 1, the prescaler is held at 0 and tick = 0.
- Time is stored as 24 h BCD: sec_l 0-9, sec_h 0-5, min_l 0-9, min_h 0-5, hour 00-23.
- On tick, the time advances by 1 s with full carry. 23:59:59 goes to 00:00:00 in a single tick.
- Set mode, per set_inc pulse while set_en = 1:
  - hour: 23 wraps to 00.
  - minute: 59 wraps to 00, no carry into hour; seconds clear to 00 on every minute increment.
  - alarm hour / alarm minute: same wrap rules as hour / minute.
- set_inc is ignored while set_en = 0. set_sel may change on any cycle.
- 12 h display is a combinational mapping of the stored hour:
  - 0 → 12, pm = 0
  - 1-11 → unchanged, pm = 0
  - 12 → 12, pm = 1
  - 13-23 → hour - 12, pm = 1
  - Minutes and seconds are unaffected.
- Chime window is qualified when set_en = 0. With CHIME_EVERY_MIN = 0, minute = 59 qualifies the pre-window and minute = 00 qualifies the post-window; with CHIME_EVERY_MIN = 1, every minute qualifies.
  - Seconds 50-58: beep_en = ~sec_l[0] (beeps on even seconds).
  - Second 59: beep_en = 1.
  - Seconds 00..CHIME_LEN-1: beep_en = 1.
  - All other seconds: beep_en = 0 from chime.
- Alarm start: alarm_active is set on the tick whose result time equals alarm_hour:alarm_minute:00, provided alarm_on = 1 and set_en = 0.
- Alarm stop: alarm_active clears on whichever comes first:
  - alarm_ack pulse (cleared on the next edge),
  - alarm_on = 0,
  - set_en = 1,
  - ALARM_SEC ticks after start (internal second counter).
- If alarm_ack and the alarm match tick occur in the same cycle, the alarm starts. alarm_ack only stops an alarm already ringing.
- While alarm_active = 1, beep_en = 1, OR'd with the chime term.
- Editing the alarm time while the alarm is ringing is impossible, because set_en already stops it.
- beep_en is registered. beep is the combinational AND of beep_en and clk_audio.
- Display digits, pm and tick are combinational from registers, with no extra latency.

Test Plan:
1. CLK_DIV = 4: pulse clr, then release → all digits 0 and beep = 0; tick pulses every 4th clk; with mode_12h = 1 the display reads 12:00:00, pm = 0.
2. Set time to 23:59:58, set_en = 0 → after 2 ticks, time = 00:00:00 and the hour digits roll correctly; with mode_12h = 1, 13:05 displays 01:05 with pm = 1.
3. CHIME_EVERY_MIN = 0, run from 00:59:49 → beep_en = 1 at :50/:52/:54/:56/:58 and at :59; beep_en = 1 for 01:00:00 through 01:00:04 and 0 at 01:00:05. No chime from 01:01:50 to 01:02:05. With clk_audio toggling, beep follows it only while beep_en = 1.
4. Set mode: hour = 23, set_inc → 00. Minute = 59 at 05:59:37, set_inc → 05:00:00. Ticks during set_en produce no time change. Releasing set_en resumes counting with the prescaler starting from 0.
5. Alarm 06:30 with alarm_on = 1, ALARM_SEC = 30 → alarm_active rises on the tick reaching 06:30:00 and falls on the tick reaching 06:30:30. A rerun with alarm_ack at 06:30:10 → alarm_active clears the next cycle. A rerun with alarm_on = 0 → the alarm never starts.
6. Assert clr during an active alarm at 06:30:05 and during set_en = 1 → on the next edge, time = 00:00:00, alarm time = 00:00, alarm_active = 0, beep = 0.
